cluster_periph_eoc_responder: RTL

Slave-side responder on the cluster peripheral interconnect, attached at the SPER_EOC_ID slave port position.
- Accepts req/gnt transactions from the interconnect and returns r_valid responses.
- Holds per-core fetch-enable, sticky end-of-computation (EOC) status with mask, and a cycle counter.
- Raises a one-cycle event toward the event unit when masked EOC status becomes non-empty.

---
 rtl/cluster_periph_eoc_responder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cluster_periph_eoc_responder.sv
// rtl/cluster_periph_eoc_responder.sv - cluster peripheral EOC/fetch-enable/cycle-counter responder
// Optional macro EOC_CYCLE_STAMP_EN maps a CYCLE_CNT capture register (STAMP) at offset 0x14.
module cluster_periph_eoc_responder #(
    parameter int NB_CORES   = 8,
    parameter int ID_WIDTH   = 5,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] add_i,
    input  logic                  wen_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            be_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic                  r_opc_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [31:0]           r_rdata_o,
    input  logic [NB_CORES-1:0]   eoc_i,
    output logic [NB_CORES-1:0]   fetch_en_o,
    output logic                  eoc_event_o
);
    localparam logic [2:0] OFF_FETCH_EN   = 3'd0;
    localparam logic [2:0] OFF_EOC_STATUS = 3'd1;
    localparam logic [2:0] OFF_EOC_MASK   = 3'd2;
    localparam logic [2:0] OFF_CYCLE_CNT  = 3'd3;
    localparam logic [2:0] OFF_CTRL       = 3'd4;
`ifdef EOC_CYCLE_STAMP_EN
    localparam logic [2:0] OFF_STAMP      = 3'd5;
    logic [31:0]         stamp;
`endif

    logic [NB_CORES-1:0] fetch_en;
    logic [NB_CORES-1:0] eoc_status;
    logic [NB_CORES-1:0] eoc_mask;
    logic [31:0]         cycle_cnt;
    logic                cnt_en;
    logic                masked_any;
    logic                masked_any_q;
    logic [2:0]          off;
    logic                wr;
    logic                cnt_clr;
    logic [31:0]         bit_en;
    logic [NB_CORES-1:0] core_wdata;
    logic [NB_CORES-1:0] core_bit_en;
    logic [31:0]         rdata;
    logic                err;
    logic                unused_addr;

    assign off         = add_i[4:2];
    assign wr          = req_i & ~wen_i;
    assign bit_en      = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    assign core_wdata  = wdata_i[NB_CORES-1:0];
    assign core_bit_en = bit_en[NB_CORES-1:0];
    assign cnt_clr     = wr && (off == OFF_CTRL) && be_i[0] && wdata_i[1];
    assign masked_any  = |(eoc_status & eoc_mask);
    assign gnt_o       = req_i;
    assign fetch_en_o  = fetch_en;
    assign unused_addr = ^{add_i[ADDR_WIDTH-1:5], add_i[1:0]};

    // Read data reflects state before this cycle's write lands.
    always_comb begin
        rdata = '0;
        err   = 1'b0;
        case (off)
            OFF_FETCH_EN:   rdata = 32'(fetch_en);
            OFF_EOC_STATUS: rdata = 32'(eoc_status);
            OFF_EOC_MASK:   rdata = 32'(eoc_mask);
            OFF_CYCLE_CNT:  rdata = cycle_cnt;
            OFF_CTRL:       rdata = {31'd0, cnt_en};
`ifdef EOC_CYCLE_STAMP_EN
            OFF_STAMP:      rdata = stamp;
`endif
            default:        err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_o    <= 1'b0;
            r_opc_o      <= 1'b0;
            r_id_o       <= '0;
            r_rdata_o    <= '0;
            fetch_en     <= '0;
            eoc_status   <= '0;
            eoc_mask     <= '0;
            cycle_cnt    <= '0;
            cnt_en       <= 1'b0;
            masked_any_q <= 1'b0;
            eoc_event_o  <= 1'b0;
`ifdef EOC_CYCLE_STAMP_EN
            stamp        <= '0;
`endif
        end else begin
            r_valid_o <= req_i;
            if (req_i) begin
                r_id_o    <= id_i;
                r_opc_o   <= err;
                r_rdata_o <= wen_i ? rdata : 32'd0;
            end
            if (wr && (off == OFF_FETCH_EN))
                fetch_en <= (fetch_en & ~core_bit_en) | (core_wdata & core_bit_en);
            if (wr && (off == OFF_EOC_MASK))
                eoc_mask <= (eoc_mask & ~core_bit_en) | (core_wdata & core_bit_en);
            // A new EOC on the same bit overrides a concurrent W1C.
            if (wr && (off == OFF_EOC_STATUS))
                eoc_status <= (eoc_status & ~(core_wdata & core_bit_en)) | eoc_i;
            else
                eoc_status <= eoc_status | eoc_i;
            if (cnt_clr)
                cycle_cnt <= '0;
            else if (wr && (off == OFF_CYCLE_CNT))
                cycle_cnt <= (cycle_cnt & ~bit_en) | (wdata_i & bit_en);
            else if (cnt_en)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (wr && (off == OFF_CTRL) && be_i[0])
                cnt_en <= wdata_i[0];
            masked_any_q <= masked_any;
            eoc_event_o  <= masked_any & ~masked_any_q;
`ifdef EOC_CYCLE_STAMP_EN
            if (masked_any && !masked_any_q)
                stamp <= cycle_cnt;
`endif
        end
    end
endmodule
